usb3_slfifo_tx: RTL and testbench

//   FPGA->host write master for the FX3 slave-FIFO bus; the opposite direction of the host->FPGA read path.

---
 rtl/usb3_slfifo_tx.sv | 126 ++++++++++++
 tb/tb_usb3_slfifo_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_slfifo_tx.sv
// rtl/usb3_slfifo_tx.sv - FX3 slave-FIFO write master: bursts a 32-bit valid/ready stream into one FX3 socket.
// Bus outputs are registered; a word accepted on a handshake is strobed onto DQ one cycle later.
module usb3_slfifo_tx #(
  parameter int          BURST_LEN = 256,
  parameter int          TURN_CYC  = 4,
  parameter int          TIMEOUT   = 1024,
  parameter logic [1:0]  SOCKET    = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  input  logic        USB3_FLAGB,
  output logic [31:0] USB3_DQ_O,
  output logic        USB3_DQ_OE,
  output logic        USB3_SLCS_N,
  output logic        USB3_SLWR_N,
  output logic        USB3_PKTEND_N,
  output logic [1:0]  USB3_A,
  output logic        busy,
  output logic [15:0] pkt_count
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(((TIMEOUT > TURN_CYC) ? TIMEOUT : TURN_CYC) + 1);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(BURST_LEN);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TURN_END  = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, TURN} state_t;

  state_t        state;
  logic          flagb_q;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] timer;
  logic          hs;

  assign tx_ready = (state == WRITE) && (beat_cnt < BEAT_MAX);
  assign hs       = tx_valid && tx_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      flagb_q       <= 1'b0;
      beat_cnt      <= '0;
      timer         <= '0;
      pkt_count     <= 16'd0;
      USB3_DQ_O     <= 32'd0;
      USB3_DQ_OE    <= 1'b0;
      USB3_SLCS_N   <= 1'b1;
      USB3_SLWR_N   <= 1'b1;
      USB3_PKTEND_N <= 1'b1;
      USB3_A        <= SOCKET;
    end else begin
      flagb_q <= USB3_FLAGB;
      USB3_A  <= SOCKET;
      case (state)
        IDLE: begin
          USB3_SLWR_N   <= 1'b1;
          USB3_PKTEND_N <= 1'b1;
          if (tx_valid && flagb_q) begin
            state       <= WRITE;
            USB3_SLCS_N <= 1'b0;
            USB3_DQ_OE  <= 1'b1;
            beat_cnt    <= '0;
            timer       <= '0;
          end
        end
        WRITE: begin
          USB3_PKTEND_N <= 1'b1;
          if (hs) begin
            USB3_DQ_O   <= tx_data;
            USB3_SLWR_N <= 1'b0;
            beat_cnt    <= beat_cnt + 1'b1;
            timer       <= '0;
            // A full buffer commits itself on the FX3 side, so the last beat never gets PKTEND.
            if (beat_cnt == BEAT_LAST) begin
              pkt_count <= pkt_count + 16'd1;
              state     <= TURN;
            end else if (tx_last) begin
              USB3_PKTEND_N <= 1'b0;
              pkt_count     <= pkt_count + 16'd1;
              state         <= TURN;
            end
          end else begin
            USB3_SLWR_N <= 1'b1;
            if (beat_cnt != '0) begin
              if (timer == TIMER_END) begin
                state <= FLUSH;
                timer <= '0;
              end else begin
                timer <= timer + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          USB3_SLWR_N   <= 1'b1;
          USB3_PKTEND_N <= 1'b0;
          pkt_count     <= pkt_count + 16'd1;
          timer         <= '0;
          state         <= TURN;
        end
        TURN: begin
          // DQ_OE drops one cycle in, after the final strobe has been presented.
          USB3_SLWR_N   <= 1'b1;
          USB3_PKTEND_N <= 1'b1;
          USB3_DQ_OE    <= 1'b0;
          if (timer == TURN_END) begin
            USB3_SLCS_N <= 1'b1;
            timer       <= '0;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb3_slfifo_tx.sv
// tb/tb_usb3_slfifo_tx.sv - bench for usb3_slfifo_tx: packet-level reference model against the logged FX3 bus.
module tb_usb3_slfifo_tx;
  localparam int         BURST = 256;
  localparam int         TURNC = 4;
  localparam int         TMO   = 16;
  localparam logic [1:0] SOCK  = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tx_data = 32'd0;
  logic        tx_valid = 1'b0;
  logic        tx_last = 1'b0;
  logic        tx_ready;
  logic        flagb = 1'b0;
  logic [31:0] dq_o;
  logic        dq_oe, slcs_n, slwr_n, pktend_n, busy;
  logic [1:0]  addr;
  logic [15:0] pkt_count;

  int errors = 0;
  int checks = 0;
  int cnt = 0;
  int commits = 0;
  int flag_mode = 1;
  bit mon_en = 1'b0;
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];

  usb3_slfifo_tx #(.BURST_LEN(BURST), .TURN_CYC(TURNC), .TIMEOUT(TMO), .SOCKET(SOCK)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .USB3_FLAGB(flagb), .USB3_DQ_O(dq_o), .USB3_DQ_OE(dq_oe), .USB3_SLCS_N(slcs_n),
    .USB3_SLWR_N(slwr_n), .USB3_PKTEND_N(pktend_n), .USB3_A(addr),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FLAGB: 0 = held low, 1 = held high, other = random with mostly space available
  always @(posedge clk) begin
    #1;
    case (flag_mode)
      0: flagb = 1'b0;
      1: flagb = 1'b1;
      default: flagb = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Bus event log entry: {write strobe, pktend strobe, data}
  always @(negedge clk) begin
    if (mon_en && (!slwr_n || !pktend_n)) begin
      obs_q.push_back({~slwr_n, ~pktend_n, slwr_n ? 32'h0 : dq_o});
      check("bus_ctl", {slcs_n, dq_oe, addr}, {1'b0, 1'b1, SOCK});
    end
  end

  task automatic model_word(input logic [31:0] d, input logic l);
    cnt++;
    exp_q.push_back({1'b1, (l && cnt < BURST), d});
    if (l || cnt == BURST) begin
      commits++;
      cnt = 0;
    end
  endtask

  task automatic model_flush();
    if (cnt > 0) begin
      exp_q.push_back({2'b01, 32'h0});
      commits++;
      cnt = 0;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    logic hs;
    int n;
    hs = 1'b0;
    n = 0;
    model_word(d, l);
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = tx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 4000);
    if (!hs) check("hs_timeout", 64'd0, 64'd1);
    tx_valid = 1'b0;
    tx_last = 1'b0;
  endtask

  task automatic idle(input int n);
    tx_valid = 1'b0;
    if (n >= TMO) model_flush();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tx_valid = 1'b0;
    model_flush();
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    if (busy) check("idle_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_events"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_ev"}, obs_q[i], exp_q[i]);
    check({tag, "_pkt"}, pkt_count, commits);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    int bad;
    bit seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {slcs_n, slwr_n, pktend_n, dq_oe}, 4'b1110);
    check("rst_dq", dq_o, 32'h0);
    check("rst_a", addr, SOCK);
    check("rst_misc", {tx_ready, busy}, 2'b00);
    check("rst_pkt", pkt_count, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    idle(3);

    // full 256-word burst, tx_last on the final word
    for (int i = 0; i < BURST; i++) send(32'(i), i == BURST - 1);
    wait_idle();
    compare_log("t1_full");

    // short packet committed with PKTEND on its last word, then TURN
    for (int i = 0; i < 10; i++) send(32'hA000_0000 + 32'(i), i == 9);
    n = 0;
    do begin
      @(negedge clk);
      if (busy) n++;
    end while (busy && n < 50);
    check("t2_turn_len", n, TURNC);
    @(posedge clk);
    #1;
    wait_idle();
    compare_log("t2_short");

    // FLAGB held low blocks the start; latency from FLAGB rising to first strobe
    flag_mode = 0;
    idle(3);
    tx_data = 32'hF1A6_0003;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_ready || !slwr_n || busy) bad++;
    end
    check("t3_flagb_hold", bad, 0);
    flag_mode = 1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (!slwr_n) seen = 1'b1;
    end
    tx_valid = 1'b0;
    tx_last = 1'b0;
    check("t3_rise_lat", n, 4);
    model_word(32'hF1A6_0003, 1'b1);
    @(posedge clk);
    #1;
    wait_idle();
    compare_log("t3_flagb");

    // valid gap before every third word
    for (int i = 0; i < BURST; i++) begin
      if (i % 3 == 2) idle(1);
      send(32'h0400_0000 + 32'(i), 1'b0);
    end
    wait_idle();
    compare_log("t4_gaps");

    // stalled partial packet gets a short-packet flush
    for (int i = 0; i < 5; i++) send(32'h0500_0000 + 32'(i), 1'b0);
    idle(40);
    wait_idle();
    compare_log("t5_flush");

    // reset in the middle of a burst abandons the packet
    for (int i = 0; i < 100; i++) send(32'h0600_0000 + 32'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_ctl", {slcs_n, slwr_n, pktend_n, dq_oe}, 4'b1110);
    check("t6_misc", {tx_ready, busy}, 2'b00);
    check("t6_pkt", pkt_count, 16'd0);
    cnt = 0;
    commits = 0;
    compare_log("t6_abandon");
    @(posedge clk);
    #1;
    for (int i = 0; i < BURST; i++) send(32'h0700_0000 + 32'(i), 1'b0);
    wait_idle();
    compare_log("t6_after");

    // randomized packets, gaps and FLAGB
    flag_mode = 2;
    for (int p = 0; p < 8; p++) begin
      int len;
      bit lst;
      len = $urandom_range(1, 300);
      lst = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) idle(40);
        else if (r < 25) idle($urandom_range(1, 3));
        send($urandom, lst && (i == len - 1));
      end
      if ($urandom_range(0, 1) == 1) idle(40);
    end
    wait_idle();
    compare_log("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
